mvb_frame_parser: RTL and testbench



---
 rtl/mvb_frame_parser.sv | 245 ++++++++++++++++++++++++
 tb/tb_mvb_frame_parser.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvb_frame_parser.sv
// MVB frame parser: on each end-of-frame pulse, reads one frame out of the decode FIFO,
// splits master frames into F_code/address, streams slave frames word by word, and
// discards frames with line errors, bad lengths, overruns or reserved F_codes.
module mvb_frame_parser #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_over,
    input  logic             frame_is_master,
    input  logic             length_error,
    input  logic             signal_error,
    input  logic             delimiter_error,
    input  logic             quality_error,
    input  logic             crc_error,
    input  logic [15:0]      fifo_data,
    input  logic             fifo_empty,
    input  logic [4:0]       fifo_count,
    output logic             fifo_rden,
    output logic             m_valid,
    output logic [3:0]       m_fcode,
    output logic [11:0]      m_addr,
    output logic             s_valid,
    output logic [15:0]      s_data,
    output logic [3:0]       s_index,
    output logic             s_last,
    output logic             frame_done,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] ErrOk       = 3'd0;
    localparam logic [2:0] ErrLine     = 3'd1;
    localparam logic [2:0] ErrSize     = 3'd2;
    localparam logic [2:0] ErrEmpty    = 3'd3;
    localparam logic [2:0] ErrOverrun  = 3'd4;
    localparam logic [2:0] ErrReserved = 3'd5;

    typedef enum logic [2:0] {StInit, StIdle, StCheck, StRead, StFlush, StDone} state_e;

    state_e     state_q;
    logic       run_q;        // low for the first clk after reset so INIT never reads in reset
    logic       fo_q;
    logic       rise_q;
    logic       err_latch_q;
    logic       err_snap_q;
    logic       is_m_q;
    logic [4:0] words_q;
    logic [4:0] remain_q;
    logic       rd_pend_q;    // a read was issued last clk, fifo_data is valid now
    logic [3:0] idx_q;
    logic [2:0] code_q;
    logic       ovr_q;
    logic       m_pend_q;
    logic [4:0] exp_len_q;

    logic       err_any;
    logic       reading;
    logic       frame_end;
    logic       fcode_rsvd;
    logic [2:0] check_code;
    logic [2:0] done_code;

    // Expected slave length implied by an accepted master F_code
    function automatic logic [4:0] slave_len(input logic [3:0] fc);
        logic [4:0] len;
        len = 5'd1;
        if (fc <= 4'd4) begin
            len = 5'd1 << fc;
        end
        return len;
    endfunction

    // Read enable, frame-check decision and completion code
    always_comb begin
        err_any   = length_error | signal_error | delimiter_error | quality_error | crc_error;
        reading   = (state_q == StRead) || (state_q == StFlush);
        frame_end = reading && (remain_q == 5'd0) && !rd_pend_q;
        fifo_rden = 1'b0;
        if (run_q && !fifo_empty) begin
            if (state_q == StInit) begin
                fifo_rden = 1'b1;
            end else if (reading && (remain_q != 5'd0)) begin
                fifo_rden = 1'b1;
            end
        end

        fcode_rsvd = (fifo_data[15:12] >= 4'd5) && (fifo_data[15:12] <= 4'd7);

        check_code = ErrOk;
        if (words_q == 5'd0) begin
            check_code = ErrEmpty;
        end else if (err_snap_q) begin
            check_code = ErrLine;
        end else if (is_m_q && (words_q != 5'd1)) begin
            check_code = ErrSize;
        end else if (!is_m_q && m_pend_q && (exp_len_q != words_q)) begin
            check_code = ErrSize;
        end else if (!is_m_q && !m_pend_q && (words_q > 5'd16)) begin
            check_code = ErrSize;
        end

        // An earlier error code wins over an overrun
        if (code_q != ErrOk) begin
            done_code = code_q;
        end else if (ovr_q || rise_q) begin
            done_code = ErrOverrun;
        end else begin
            done_code = ErrOk;
        end
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInit;
            run_q       <= 1'b0;
            fo_q        <= 1'b0;
            rise_q      <= 1'b0;
            err_latch_q <= 1'b0;
            err_snap_q  <= 1'b0;
            is_m_q      <= 1'b0;
            words_q     <= 5'd0;
            remain_q    <= 5'd0;
            rd_pend_q   <= 1'b0;
            idx_q       <= 4'd0;
            code_q      <= ErrOk;
            ovr_q       <= 1'b0;
            m_pend_q    <= 1'b0;
            exp_len_q   <= 5'd0;
            m_valid     <= 1'b0;
            m_fcode     <= 4'd0;
            m_addr      <= 12'd0;
            s_valid     <= 1'b0;
            s_data      <= 16'd0;
            s_index     <= 4'd0;
            s_last      <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ErrOk;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            run_q      <= 1'b1;
            fo_q       <= frame_over;
            rise_q     <= frame_over & ~fo_q;
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            s_last     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ErrOk;

            err_latch_q <= (state_q == StDone) ? 1'b0 : (err_latch_q | err_any);

            // A completion arriving while busy is not processed; its words stay in the FIFO
            if (rise_q && (state_q != StIdle)) begin
                ovr_q <= 1'b1;
            end

            if (reading) begin
                rd_pend_q <= fifo_rden;
                if (fifo_rden) begin
                    remain_q <= remain_q - 5'd1;
                end
            end

            unique case (state_q)
                StInit: begin
                    ovr_q <= 1'b0;
                    if (fifo_empty) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (rise_q) begin
                        words_q    <= fifo_count;
                        is_m_q     <= frame_is_master;
                        err_snap_q <= err_latch_q | err_any;
                        state_q    <= StCheck;
                    end
                end
                StCheck: begin
                    code_q    <= check_code;
                    remain_q  <= words_q;
                    idx_q     <= 4'd0;
                    rd_pend_q <= 1'b0;
                    m_pend_q  <= 1'b0;
                    state_q   <= (check_code == ErrOk) ? StRead : StFlush;
                end
                StRead: begin
                    if (rd_pend_q) begin
                        if (is_m_q) begin
                            if (fcode_rsvd) begin
                                code_q <= ErrReserved;
                            end else begin
                                m_valid <= 1'b1;
                                m_fcode <= fifo_data[15:12];
                                m_addr  <= fifo_data[11:0];
                            end
                        end else begin
                            s_valid <= 1'b1;
                            s_data  <= fifo_data;
                            s_index <= idx_q;
                            s_last  <= ({1'b0, idx_q} == (words_q - 5'd1));
                            idx_q   <= idx_q + 4'd1;
                        end
                    end
                end
                StFlush: begin
                end
                StDone: begin
                    ovr_q   <= 1'b0;
                    code_q  <= ErrOk;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase

            // Completion: one clk after the last strobe, or after the last flushed word
            if (frame_end) begin
                state_q    <= StDone;
                frame_done <= 1'b1;
                frame_err  <= (done_code != ErrOk);
                err_code   <= done_code;
                if (done_code == ErrOk) begin
                    if (frame_cnt != '1) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                    if (is_m_q) begin
                        m_pend_q  <= 1'b1;
                        exp_len_q <= slave_len(m_fcode);
                    end
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mvb_frame_parser.sv
// Bench for mvb_frame_parser: behavioural decode-FIFO, per-frame reference model of the
// classification rules, directed scenarios followed by randomized frames.
`timescale 1ns/1ps
module tb_mvb_frame_parser;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_over;
    logic             frame_is_master;
    logic             length_error, signal_error, delimiter_error, quality_error, crc_error;
    logic [15:0]      fifo_data;
    logic             fifo_empty;
    logic [4:0]       fifo_count;
    logic             fifo_rden;
    logic             m_valid;
    logic [3:0]       m_fcode;
    logic [11:0]      m_addr;
    logic             s_valid;
    logic [15:0]      s_data;
    logic [3:0]       s_index;
    logic             s_last;
    logic             frame_done;
    logic             frame_err;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    mvb_frame_parser #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_over      (frame_over),
        .frame_is_master (frame_is_master),
        .length_error    (length_error),
        .signal_error    (signal_error),
        .delimiter_error (delimiter_error),
        .quality_error   (quality_error),
        .crc_error       (crc_error),
        .fifo_data       (fifo_data),
        .fifo_empty      (fifo_empty),
        .fifo_count      (fifo_count),
        .fifo_rden       (fifo_rden),
        .m_valid         (m_valid),
        .m_fcode         (m_fcode),
        .m_addr          (m_addr),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_index         (s_index),
        .s_last          (s_last),
        .frame_done      (frame_done),
        .frame_err       (frame_err),
        .err_code        (err_code),
        .frame_cnt       (frame_cnt),
        .err_cnt         (err_cnt)
    );

    // Standard (non-FWFT) FIFO model; stall forces it to look empty
    logic [15:0] fmem [0:31];
    int          wp = 0;
    int          rp = 0;
    logic        stall = 1'b0;
    assign fifo_empty = (wp == rp) || stall;
    assign fifo_count = 5'(wp - rp);
    always @(posedge clk) begin
        if (fifo_rden && !fifo_empty) begin
            fifo_data <= fmem[rp % 32];
            rp <= rp + 1;
        end
    end

    // Event monitor, sampled well after the active edge
    logic [31:0] mq[$];
    logic [31:0] sq[$];
    logic [31:0] dq[$];
    int rden_cnt = 0;
    int rden_stall_cnt = 0;
    int slast_bad = 0;
    always @(posedge clk) begin
        #2;
        if (m_valid) mq.push_back({16'h0, m_fcode, m_addr});
        if (s_valid) sq.push_back({11'h0, s_last, s_index, s_data});
        if (frame_done) dq.push_back({28'h0, frame_err, err_code});
        if (fifo_rden) rden_cnt++;
        if (fifo_rden && stall) rden_stall_cnt++;
        if (!s_valid && s_last) slast_bad++;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          mp = 1'b0;
    logic [4:0]  mexp = 5'd0;
    int          mf = 0;
    int          me = 0;
    logic [15:0] fw [0:31];
    int          fn;
    int          err_sel = 4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] w);
        fmem[wp % 32] = w;
        wp = wp + 1;
    endtask

    task automatic pulse_err();
        case (err_sel)
            0: length_error = 1'b1;
            1: signal_error = 1'b1;
            2: delimiter_error = 1'b1;
            3: quality_error = 1'b1;
            default: crc_error = 1'b1;
        endcase
        tick(1);
        {length_error, signal_error, delimiter_error, quality_error, crc_error} = 5'b0;
    endtask

    // One frame: model prediction, stimulus, and comparison of every observed event
    task automatic run_frame(input string tag, input bit is_m, input bit line_err,
                             input bit do_ovr, input bit do_stall);
        int code, pre, guard, nm, ns;
        bit acted;
        logic [3:0] fc;
        code = 0;
        if (fn == 0) code = 3;
        else if (line_err) code = 1;
        else if (is_m && fn != 1) code = 2;
        else if (!is_m && mp && int'(mexp) != fn) code = 2;
        else if (!is_m && !mp && fn > 16) code = 2;
        fc = fw[0][15:12];
        if (code == 0 && is_m && fc >= 5 && fc <= 7) code = 5;
        pre = code;
        if (do_ovr && code == 0) code = 4;
        nm = (pre == 0 && is_m) ? 1 : 0;
        ns = (pre == 0 && !is_m) ? fn : 0;
        mp = is_m && (code == 0);
        if (mp) mexp = (fc <= 4) ? (5'd1 << fc) : 5'd1;
        if (code == 0) mf++; else me++;

        mq.delete(); sq.delete(); dq.delete();
        rden_cnt = 0; rden_stall_cnt = 0;
        for (int i = 0; i < fn; i++) push(fw[i]);
        if (line_err) pulse_err();
        frame_is_master = is_m;
        frame_over = 1'b1;
        acted = 1'b0;
        guard = 0;
        while (dq.size() == 0 && guard < 400) begin
            tick(1);
            guard++;
            if (!acted && sq.size() > 0) begin
                acted = 1'b1;
                if (do_ovr) begin
                    frame_over = 1'b0;
                    tick(2);
                    frame_over = 1'b1;
                end
                if (do_stall) begin
                    stall = 1'b1;
                    tick(5);
                    stall = 1'b0;
                end
            end
        end
        tick(2);
        frame_over = 1'b0;
        tick(3);

        chk({tag, ".done_seen"}, 32'(guard < 400), 1);
        chk({tag, ".done_count"}, dq.size(), 1);
        if (dq.size() > 0) begin
            chk({tag, ".err_code"}, dq[0][2:0], code);
            chk({tag, ".frame_err"}, dq[0][3], code != 0);
        end
        chk({tag, ".m_count"}, mq.size(), nm);
        if (nm == 1 && mq.size() > 0) chk({tag, ".m_word"}, mq[0], {16'h0, fw[0]});
        chk({tag, ".s_count"}, sq.size(), ns);
        for (int i = 0; i < ns && i < sq.size(); i++)
            chk({tag, ".s_word"}, sq[i], {11'h0, (i == fn - 1), 4'(i), fw[i]});
        chk({tag, ".rden_count"}, rden_cnt, fn);
        chk({tag, ".fifo_drained"}, rp, wp);
        chk({tag, ".frame_cnt"}, frame_cnt, mf);
        chk({tag, ".err_cnt"}, err_cnt, me);
        chk({tag, ".s_last_idle"}, slast_bad, 0);
        if (do_stall) chk({tag, ".rden_in_stall"}, rden_stall_cnt, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rden"}, fifo_rden, 0);
        chk({tag, ".strobes"}, {m_valid, s_valid, s_last, frame_done, frame_err}, 0);
        chk({tag, ".data"}, {m_fcode, m_addr, s_data}, 0);
        chk({tag, ".idx_code"}, {s_index, err_code}, 0);
        chk({tag, ".counters"}, {frame_cnt, err_cnt}, 0);
    endtask

    initial begin
        bit im, le;
        int n, guard;
        rst = 1'b0;
        frame_over = 1'b0;
        frame_is_master = 1'b0;
        {length_error, signal_error, delimiter_error, quality_error, crc_error} = 5'b0;

        // Reset with stale words: nothing read while in reset, INIT drains afterwards
        push(16'hDEAD); push(16'hBEEF); push(16'h0123);
        tick(3);
        #1;
        check_zero("reset");
        rst = 1'b1;
        tick(12);
        chk("init.drained", rp, 3);
        chk("init.no_events", mq.size() + sq.size() + dq.size(), 0);

        fn = 1; fw[0] = 16'h3A5C; run_frame("master", 1, 0, 0, 0);
        fn = 1; fw[0] = 16'h2123; run_frame("master_f2", 1, 0, 0, 0);
        fn = 4; fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'h3333; fw[3] = 16'h4444;
        run_frame("slave4", 0, 0, 0, 0);
        fn = 1; fw[0] = 16'h1456; run_frame("master_f1", 1, 0, 0, 0);
        fn = 3; fw[0] = 16'hAAAA; fw[1] = 16'hBBBB; fw[2] = 16'hCCCC;
        run_frame("len_mismatch", 0, 0, 0, 0);
        err_sel = 4;
        fn = 1; fw[0] = 16'h5A5A; run_frame("crc_slave", 0, 1, 0, 0);
        fn = 1; fw[0] = 16'h8001; run_frame("clean_master", 1, 0, 0, 0);
        fn = 1; fw[0] = 16'h6123; run_frame("rsvd_fcode", 1, 0, 0, 0);
        fn = 1; fw[0] = 16'h4000; run_frame("master_f4", 1, 0, 0, 0);
        fn = 16;
        for (int i = 0; i < 16; i++) fw[i] = 16'($urandom);
        run_frame("overrun", 0, 0, 1, 0);
        fn = 1; fw[0] = 16'h3ABC; run_frame("master_f3", 1, 0, 0, 0);
        fn = 8;
        for (int i = 0; i < 8; i++) fw[i] = 16'($urandom);
        run_frame("stall", 0, 0, 0, 1);
        fn = 2; fw[0] = 16'h0001; fw[1] = 16'h0002; run_frame("master_len2", 1, 0, 0, 0);
        fn = 0; run_frame("empty", 0, 0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            im = 1'($urandom_range(0, 1));
            le = ($urandom_range(0, 7) == 0);
            err_sel = $urandom_range(0, 4);
            if (im) n = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : 1;
            else if (mp && $urandom_range(0, 3) != 0) n = int'(mexp);
            else n = $urandom_range(0, 18);
            fn = n;
            for (int i = 0; i < n; i++) fw[i] = 16'($urandom);
            run_frame("random", im, le, 0, 0);
        end

        // Reset in the middle of a slave read
        fn = 1; fw[0] = 16'h3000; run_frame("master_pre_rst", 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) push(16'($urandom));
        frame_is_master = 1'b0;
        frame_over = 1'b1;
        sq.delete();
        guard = 0;
        while (sq.size() == 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        chk("midrst.strobe_seen", 32'(guard < 100), 1);
        rst = 1'b0;
        frame_over = 1'b0;
        #1;
        check_zero("midrst");
        mp = 1'b0; mf = 0; me = 0;
        tick(2);
        mq.delete(); sq.delete(); dq.delete();
        rst = 1'b1;
        tick(20);
        chk("midrst.drained", rp, wp);
        chk("midrst.no_events", mq.size() + sq.size() + dq.size(), 0);
        fn = 1; fw[0] = 16'h0FFF; run_frame("post_rst", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
